timer_counter: RTL

//   Memory-mapped down-counting timer on the CPU data bus, downstream of the M-stage store/load path.
//   The CPU configures it with sw and reads it back with lw.
//   It raises irq on expiry; the interrupt controller consumes irq.

---
 rtl/timer_counter_pkg.sv | 69 ++++++
 rtl/tc_prescaler.sv | 50 +++++
 rtl/timer_counter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_pkg.sv
// -----------------------------------------------------------------------------
// timer_counter_pkg
//   Shared definitions for the memory-mapped down-counting timer:
//   - register word offsets (address bits [3:2])
//   - FSM state codes
//   - MODE encodings
//   - CTRL bit positions and the packed CTRL layout
//   - helpers to decode a CTRL store and to build the CTRL read value
//   No ports; imported by timer_counter and tc_prescaler.
// -----------------------------------------------------------------------------
package timer_counter_pkg;

    // Register word offsets.
    localparam logic [1:0] TC_CTRL   = 2'd0;  // byte 0x0
    localparam logic [1:0] TC_PRESET = 2'd1;  // byte 0x4
    localparam logic [1:0] TC_COUNT  = 2'd2;  // byte 0x8, read-only

    // MODE encodings; 2'b1x is treated as one-shot.
    localparam logic [1:0] TC_MODE_ONESHOT = 2'b00;
    localparam logic [1:0] TC_MODE_RELOAD  = 2'b01;

    // CTRL bit positions.
    localparam int TC_CTRL_EN_BIT   = 0;
    localparam int TC_CTRL_MODE_LSB = 1;
    localparam int TC_CTRL_IM_BIT   = 3;
    localparam int TC_CTRL_PS_LSB   = 4;
    localparam int TC_PS_W          = 8;

    typedef enum logic [1:0] {
        TC_IDLE = 2'd0,
        TC_LOAD = 2'd1,
        TC_CNT  = 2'd2,
        TC_INT  = 2'd3
    } tc_state_e;

    typedef struct packed {
        logic [TC_PS_W-1:0] ps;    // prescale divisor minus one
        logic               im;    // irq mask (1 = irq visible)
        logic [1:0]         mode;  // 00 one-shot, 01 auto-reload
        logic               en;    // timer enable
    } tc_ctrl_t;

    // Decode the low CTRL bits of a store into fields.
    function automatic tc_ctrl_t ctrl_unpack(input logic [11:0] w);
        tc_ctrl_t c;
        c.en   = w[TC_CTRL_EN_BIT];
        c.mode = w[TC_CTRL_MODE_LSB +: 2];
        c.im   = w[TC_CTRL_IM_BIT];
        c.ps   = w[TC_CTRL_PS_LSB +: TC_PS_W];
        return c;
    endfunction

    // Place CTRL fields at their bus positions; every other bit reads 0.
    function automatic logic [31:0] ctrl_read(input tc_ctrl_t c);
        logic [31:0] r;
        r = '0;
        r[TC_CTRL_EN_BIT]                = c.en;
        r[TC_CTRL_MODE_LSB +: 2]         = c.mode;
        r[TC_CTRL_IM_BIT]                = c.im;
        r[TC_CTRL_PS_LSB +: TC_PS_W]     = c.ps;
        return r;
    endfunction

    // Collapse the reserved MODE codes onto one-shot.
    function automatic logic [1:0] mode_eff(input logic [1:0] mode);
        return (mode == TC_MODE_RELOAD) ? TC_MODE_RELOAD : TC_MODE_ONESHOT;
    endfunction

endpackage

// File: rtl/tc_prescaler.sv
// -----------------------------------------------------------------------------
// tc_prescaler
//   8-bit divider for the timer: while en is high it emits one tick every
//   ps+1 cycles. clr restarts the division from zero. Only compiled into the
//   design when TC_PRESCALE_EN is defined.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-low
//   clr    in   restart division (timer LOAD or EN=0)
//   en     in   count this cycle (timer in CNT with EN set)
//   ps     in   divisor minus one
//   tick   out  decrement strobe for the timer counter
// -----------------------------------------------------------------------------
`ifdef TC_PRESCALE_EN
module tc_prescaler
    import timer_counter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    input  logic [TC_PS_W-1:0] ps,
    output logic               tick
);

    logic [TC_PS_W-1:0] div_q;
    logic [TC_PS_W-1:0] div_d;

    // >= rather than == so a PS lowered mid-count cannot strand the divider.
    assign tick = en && (div_q >= ps);

    always_comb begin
        div_d = div_q;
        if (clr) begin
            div_d = '0;
        end else if (en) begin
            div_d = tick ? '0 : div_q + TC_PS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule
`endif

// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
//   Memory-mapped down-counting timer on the CPU data bus. The CPU programs
//   CTRL/PRESET with stores and reads CTRL/PRESET/COUNT with loads; a level
//   interrupt is raised on expiry.
//   Registers (word offset = addr):
//     0 CTRL   [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x one-shot),
//              [3] IM, [11:4] PS (only with TC_PRESCALE_EN, else reads 0)
//     1 PRESET reload value
//     2 COUNT  current count, read-only
//     3 reserved, reads 0, writes ignored
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-low
//   sel    in   bridge decode hit
//   we     in   store strobe, qualified by sel
//   addr   in   word offset (A[3:2])
//   wdata  in   store data
//   rdata  out  combinational read data
//   irq    out  level interrupt = irq_flag & IM
// Build option:
//   TC_PRESCALE_EN  enables CTRL.PS and the tc_prescaler divider.
// -----------------------------------------------------------------------------
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int BASE_SEL = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sel,
    input  logic                we,
    input  logic [BASE_SEL-1:0] addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                irq
);

    localparam logic [BASE_SEL-1:0] A_CTRL   = BASE_SEL'(TC_CTRL);
    localparam logic [BASE_SEL-1:0] A_PRESET = BASE_SEL'(TC_PRESET);
    localparam logic [BASE_SEL-1:0] A_COUNT  = BASE_SEL'(TC_COUNT);

    tc_state_e        state_q, state_d;
    tc_ctrl_t         ctrl_q, ctrl_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             irq_flag_q, irq_flag_d;

    logic             ctrl_wr;
    logic             preset_wr;
    logic             stop_wr;     // CTRL store that clears EN
    tc_ctrl_t         ctrl_wval;
    logic             reload;
    logic             tick;
    logic             expire;

    // -------------------------------------------------------------------------
    // Bus decode
    // -------------------------------------------------------------------------
    assign ctrl_wr   = sel && we && (addr == A_CTRL);
    assign preset_wr = sel && we && (addr == A_PRESET);
    assign reload    = (mode_eff(ctrl_q.mode) == TC_MODE_RELOAD);

    always_comb begin
        ctrl_wval = ctrl_unpack(wdata[11:0]);
`ifndef TC_PRESCALE_EN
        ctrl_wval.ps = '0;
`endif
    end

    assign stop_wr = ctrl_wr && !ctrl_wval.en;

    // -------------------------------------------------------------------------
    // Decrement strobe
    // -------------------------------------------------------------------------
`ifdef TC_PRESCALE_EN
    tc_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   ((state_q == TC_LOAD) || !ctrl_q.en),
        .en    ((state_q == TC_CNT) && ctrl_q.en),
        .ps    (ctrl_q.ps),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // Count reaches zero on this edge; COUNT<=1 covers PRESET=0 and PRESET=1.
    assign expire = (state_q == TC_CNT) && ctrl_q.en && tick &&
                    (count_q <= CNT_W'(1));

    // -------------------------------------------------------------------------
    // State register and datapath flops
    // -------------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
    // pre-edge value of the others; blocking here would create order-dependent
    // races between always_ff blocks and mismatch gate-level behaviour.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= TC_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable assigned in an always_comb gets a default on the
    // first line; a path that skips an assignment would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (stop_wr) begin
            state_d = TC_IDLE;
        end else begin
            case (state_q)
                TC_IDLE: if (ctrl_q.en) state_d = TC_LOAD;
                TC_LOAD: state_d = TC_CNT;
                TC_CNT: begin
                    if (!ctrl_q.en) begin
                        state_d = TC_IDLE;
                    end else if (expire) begin
                        state_d = TC_INT;
                    end
                end
                TC_INT:  state_d = reload ? TC_LOAD : TC_IDLE;
                default: state_d = TC_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Register / counter update
    // -------------------------------------------------------------------------
    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        // A CPU store to CTRL wins over the one-shot EN clear.
        if (ctrl_wr) begin
            ctrl_d = ctrl_wval;
        end else if (state_q == TC_INT && !reload) begin
            ctrl_d.en = 1'b0;
        end

        // PRESET only reaches COUNT through LOAD.
        if (preset_wr) begin
            preset_d = CNT_W'(wdata);
        end

        // A stopping store freezes COUNT on the same edge.
        if (!stop_wr) begin
            case (state_q)
                TC_LOAD: count_d = preset_q;
                TC_CNT: begin
                    if (ctrl_q.en && tick) begin
                        count_d = (count_q > CNT_W'(1)) ? count_q - CNT_W'(1) : '0;
                    end
                end
                default: count_d = count_q;
            endcase
        end

        // irq_flag rises on entry to INT. Auto-reload drops it when leaving
        // INT (one-cycle pulse); one-shot keeps it until a CTRL store.
        if (ctrl_wr) begin
            irq_flag_d = 1'b0;
        end else if (expire) begin
            irq_flag_d = 1'b1;
        end else if (state_q == TC_INT && reload) begin
            irq_flag_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        irq   = irq_flag_q & ctrl_q.im;
        rdata = '0;
        if (addr == A_CTRL) begin
            rdata = ctrl_read(ctrl_q);
        end else if (addr == A_PRESET) begin
            rdata = 32'(preset_q);
        end else if (addr == A_COUNT) begin
            rdata = 32'(count_q);
        end
    end

endmodule
